// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared types and constants for the two-master Wishbone arbiter.
//   arb_state_e      : arbiter FSM states (IDLE / OWN0 / OWN1)
//   GNT_*            : one-hot grant encodings presented on the gnt port
//   WB_TIMEOUT_DATA  : read data returned to a master whose cycle was killed
//                      by the watchdog
//   gnt_of()         : maps an FSM state to its one-hot grant vector
// -----------------------------------------------------------------------------
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam logic [1:0]  GNT_NONE        = 2'b00;
    localparam logic [1:0]  GNT_M0          = 2'b01;
    localparam logic [1:0]  GNT_M1          = 2'b10;
    localparam logic [31:0] WB_TIMEOUT_DATA = 32'hDEAD_BEEF;

    function automatic logic [1:0] gnt_of(input arb_state_e st);
        logic [1:0] g;
        g = GNT_NONE;
        case (st)
            OWN0:    g = GNT_M0;
            OWN1:    g = GNT_M1;
            default: g = GNT_NONE;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/wb_arb_timeout.sv
// -----------------------------------------------------------------------------
// wb_arb_timeout
// Watchdog counter for the arbiter. Counts owned cycles without an
// acknowledge and flags expiry when the count reaches TIMEOUT.
//   clk, reset : clock and synchronous active-high reset
//   clr        : hold the count at zero (arbiter not owning the bus)
//   en         : count this cycle (owned cycle without s_ACK)
//   expire     : count has reached TIMEOUT
// Parameters: TIMEOUT (1..65535)
// -----------------------------------------------------------------------------
module wb_arb_timeout
    import wb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT);

    logic [15:0] count_q, count_d;

    assign expire = (count_q == LIMIT);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !expire) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Two-master round-robin Wishbone arbiter in front of WB_intercon. One owner
// per transaction; the grant is held until the slave acknowledges or the
// owning master drops its strobe.
//   clk, reset            : clock, synchronous active-high reset
//   m0_* / m1_*           : master ports (STB, WE, ADDR, DAT_I in; DAT_O, ACK out)
//   s_*                   : slave-side bus towards WB_intercon
//   gnt                   : one-hot current owner (00 none, 01 m0, 10 m1)
//   timeout_flag          : sticky watchdog indicator
// Parameters: ADDR_W, DATA_W, TIMEOUT
// Build option: define WB_ARB_TIMEOUT_EN to enable the watchdog; otherwise a
// transaction waits indefinitely and timeout_flag is tied low.
// -----------------------------------------------------------------------------
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_STB,
    input  logic              m0_WE,
    input  logic [ADDR_W-1:0] m0_ADDR,
    input  logic [DATA_W-1:0] m0_DAT_I,
    output logic [DATA_W-1:0] m0_DAT_O,
    output logic              m0_ACK,
    input  logic              m1_STB,
    input  logic              m1_WE,
    input  logic [ADDR_W-1:0] m1_ADDR,
    input  logic [DATA_W-1:0] m1_DAT_I,
    output logic [DATA_W-1:0] m1_DAT_O,
    output logic              m1_ACK,
    output logic              s_STB,
    output logic              s_WE,
    output logic [ADDR_W-1:0] s_ADDR,
    output logic [DATA_W-1:0] s_DAT_O,
    input  logic [DATA_W-1:0] s_DAT_I,
    input  logic              s_ACK,
    output logic [1:0]        gnt,
    output logic              timeout_flag
);

    // Master ports gathered into arrays so both routing paths share one body.
    logic [1:0]        m_stb;
    logic [1:0]        m_we;
    logic [ADDR_W-1:0] m_addr [2];
    logic [DATA_W-1:0] m_wdat [2];
    logic [DATA_W-1:0] m_rdat [2];
    logic [1:0]        m_ack;

    assign m_stb     = {m1_STB, m0_STB};
    assign m_we      = {m1_WE, m0_WE};
    assign m_addr[0] = m0_ADDR;
    assign m_addr[1] = m1_ADDR;
    assign m_wdat[0] = m0_DAT_I;
    assign m_wdat[1] = m1_DAT_I;
    assign m0_DAT_O  = m_rdat[0];
    assign m1_DAT_O  = m_rdat[1];
    assign m0_ACK    = m_ack[0];
    assign m1_ACK    = m_ack[1];

    arb_state_e state_q, state_d;
    logic       last_q, last_d;     // most recently served master (0 or 1)

    logic [1:0] own;
    logic       owner;
    logic       sel;
    logic       expire;             // raw watchdog expiry
    logic       fire;               // watchdog actually terminates this cycle

    assign own   = gnt_of(state_q);
    assign owner = (state_q != IDLE);
    assign sel   = (state_q == OWN1);

    // A genuine acknowledge wins over the watchdog, and a master that has
    // already dropped its strobe is abandoning, not timing out.
    assign fire  = owner & expire & ~s_ACK & m_stb[sel];

`ifdef WB_ARB_TIMEOUT_EN
    logic timeout_flag_q, timeout_flag_d;

    wb_arb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clr    (~owner),
        .en     (owner & ~s_ACK),
        .expire (expire)
    );

    always_comb begin
        timeout_flag_d = timeout_flag_q | fire;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_flag_q <= 1'b0;
        end else begin
            timeout_flag_q <= timeout_flag_d;
        end
    end

    assign timeout_flag = timeout_flag_q;
`else
    logic unused_timeout_cfg;

    assign expire             = 1'b0;
    assign timeout_flag       = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT == 0);
`endif

    // Next-state and round-robin bookkeeping.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m_stb == 2'b11) begin
                    // Tie: serve whichever master was not served last.
                    state_d = last_q ? OWN0 : OWN1;
                end else if (m_stb[0]) begin
                    state_d = OWN0;
                end else if (m_stb[1]) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (s_ACK || fire) begin
                    state_d = IDLE;
                    last_d  = sel;
                end else if (!m_stb[sel]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Slave-side mux: straight 2:1 select on the registered owner.
    assign s_STB   = owner & m_stb[sel] & ~fire;
    assign s_WE    = owner & m_we[sel];
    assign s_ADDR  = owner ? m_addr[sel] : '0;
    assign s_DAT_O = owner ? m_wdat[sel] : '0;
    assign gnt     = own;

    // Return path: only the owner sees the acknowledge and read data.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ret
            assign m_ack[gi]  = own[gi] & (s_ACK | fire);
            assign m_rdat[gi] = !own[gi] ? '0 :
                                fire     ? DATA_W'(WB_TIMEOUT_DATA) : s_DAT_I;
        end
    endgenerate

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
// Directed bench for wb_arbiter. Inputs change 1 ns after the rising edge and
// outputs are checked 1 ns later, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              m0_STB, m0_WE, m1_STB, m1_WE;
    logic [ADDR_W-1:0] m0_ADDR, m1_ADDR, s_ADDR;
    logic [DATA_W-1:0] m0_DAT_I, m1_DAT_I, m0_DAT_O, m1_DAT_O;
    logic              m0_ACK, m1_ACK;
    logic              s_STB, s_WE, s_ACK;
    logic [DATA_W-1:0] s_DAT_O, s_DAT_I;
    logic [1:0]        gnt;
    logic              timeout_flag;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .m0_STB       (m0_STB),
        .m0_WE        (m0_WE),
        .m0_ADDR      (m0_ADDR),
        .m0_DAT_I     (m0_DAT_I),
        .m0_DAT_O     (m0_DAT_O),
        .m0_ACK       (m0_ACK),
        .m1_STB       (m1_STB),
        .m1_WE        (m1_WE),
        .m1_ADDR      (m1_ADDR),
        .m1_DAT_I     (m1_DAT_I),
        .m1_DAT_O     (m1_DAT_O),
        .m1_ACK       (m1_ACK),
        .s_STB        (s_STB),
        .s_WE         (s_WE),
        .s_ADDR       (s_ADDR),
        .s_DAT_O      (s_DAT_O),
        .s_DAT_I      (s_DAT_I),
        .s_ACK        (s_ACK),
        .gnt          (gnt),
        .timeout_flag (timeout_flag)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one clock; inputs may be changed immediately afterwards.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        m0_STB = 0; m0_WE = 0; m0_ADDR = '0; m0_DAT_I = '0;
        m1_STB = 0; m1_WE = 0; m1_ADDR = '0; m1_DAT_I = '0;
        s_ACK = 0; s_DAT_I = '0;
    endtask

    task automatic do_reset();
        reset = 1;
        clear_inputs();
        repeat (3) step();
        reset = 0;
    endtask

    logic [1:0]  exp_owner [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [31:0] exp_addr  [4] = '{32'h100, 32'h200, 32'h100, 32'h200};

    initial begin
        // ---------------- reset ----------------
        do_reset();
        step();
        check_eq("rst_gnt", gnt, 2'b00);
        check_eq("rst_s_stb", s_STB, 0);
        check_eq("rst_s_we", s_WE, 0);
        check_eq("rst_s_addr", s_ADDR, 0);
        check_eq("rst_s_dat", s_DAT_O, 0);
        check_eq("rst_acks", {m1_ACK, m0_ACK}, 2'b00);
        check_eq("rst_m0_dat", m0_DAT_O, 0);
        check_eq("rst_m1_dat", m1_DAT_O, 0);
        check_eq("rst_flag", timeout_flag, 0);

        // ---------------- single master write ----------------
        m0_STB = 1; m0_WE = 1; m0_ADDR = 32'h0000_0010; m0_DAT_I = 32'h1234_5678;
        settle();
        check_eq("wr_latency_s_stb", s_STB, 0);
        step();
        check_eq("wr_gnt", gnt, 2'b01);
        check_eq("wr_s_stb", s_STB, 1);
        check_eq("wr_s_we", s_WE, 1);
        check_eq("wr_s_addr", s_ADDR, 32'h10);
        check_eq("wr_s_dat", s_DAT_O, 32'h1234_5678);
        check_eq("wr_no_ack_yet", m0_ACK, 0);
        step();
        check_eq("wr_wait_stb", s_STB, 1);
        step();
        s_ACK = 1;
        settle();
        check_eq("wr_m0_ack", m0_ACK, 1);
        check_eq("wr_m1_ack", m1_ACK, 0);
        step();
        clear_inputs();
        settle();
        check_eq("wr_back_idle", gnt, 2'b00);
        check_eq("wr_idle_stb", s_STB, 0);

        // ---------------- simultaneous requests ----------------
        do_reset();
        m0_STB = 1; m0_ADDR = 32'h100;
        m1_STB = 1; m1_ADDR = 32'h200;
        settle();
        check_eq("rr_start_idle", gnt, 2'b00);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq($sformatf("rr%0d_gnt", i), gnt, exp_owner[i]);
            check_eq($sformatf("rr%0d_addr", i), s_ADDR, exp_addr[i]);
            s_ACK = 1;
            settle();
            check_eq($sformatf("rr%0d_acks", i), {m1_ACK, m0_ACK}, exp_owner[i]);
            step();
            s_ACK = 0;
            settle();
            check_eq($sformatf("rr%0d_gap", i), gnt, 2'b00);
        end
        clear_inputs();

        // ---------------- read routing to m1 ----------------
        m1_STB = 1; m1_WE = 0; m1_ADDR = 32'h300;
        step();
        check_eq("rd_gnt", gnt, 2'b10);
        check_eq("rd_s_we", s_WE, 0);
        check_eq("rd_s_addr", s_ADDR, 32'h300);
        s_DAT_I = 32'hCAFE_0001; s_ACK = 1;
        settle();
        check_eq("rd_m1_dat", m1_DAT_O, 32'hCAFE_0001);
        check_eq("rd_m1_ack", m1_ACK, 1);
        check_eq("rd_m0_ack", m0_ACK, 0);
        check_eq("rd_m0_dat", m0_DAT_O, 0);
        step();
        clear_inputs();
        s_DAT_I = 32'hCAFE_0001;
        settle();
        check_eq("rd_idle_m1_dat", m1_DAT_O, 0);
        s_DAT_I = '0;

        // ---------------- abandon ----------------
        m0_STB = 1; m0_ADDR = 32'h400;
        step();
        check_eq("ab_gnt0", gnt, 2'b01);
        m0_STB = 0; m1_STB = 1; m1_ADDR = 32'h500;
        settle();
        check_eq("ab_s_stb_drop", s_STB, 0);
        check_eq("ab_no_ack", m0_ACK, 0);
        step();
        check_eq("ab_idle", gnt, 2'b00);
        step();
        check_eq("ab_gnt1", gnt, 2'b10);
        check_eq("ab_addr1", s_ADDR, 32'h500);
        s_ACK = 1;
        settle();
        check_eq("ab_m1_ack", m1_ACK, 1);
        check_eq("ab_m0_ack", m0_ACK, 0);
        step();
        clear_inputs();

        // ---------------- reset mid-transaction ----------------
        m0_STB = 1;
        step();
        check_eq("mr_gnt", gnt, 2'b01);
        reset = 1;
        step();
        check_eq("mr_dropped", gnt, 2'b00);
        check_eq("mr_no_ack", m0_ACK, 0);
        reset = 0;
        clear_inputs();
        step();

`ifdef WB_ARB_TIMEOUT_EN
        // ---------------- ACK beats watchdog on the same cycle ----------------
        m0_STB = 1;
        step();
        repeat (8) step();
        s_ACK = 1; s_DAT_I = 32'h0000_5A5A;
        settle();
        check_eq("wdp_ack", m0_ACK, 1);
        check_eq("wdp_dat", m0_DAT_O, 32'h0000_5A5A);
        step();
        clear_inputs();
        settle();
        check_eq("wdp_no_flag", timeout_flag, 0);

        // ---------------- watchdog fires ----------------
        m0_STB = 1;
        step();
        for (int k = 0; k < 8; k++) begin
            check_eq($sformatf("wd_wait%0d_ack", k), m0_ACK, 0);
            check_eq($sformatf("wd_wait%0d_stb", k), s_STB, 1);
            step();
        end
        check_eq("wd_ack", m0_ACK, 1);
        check_eq("wd_dat", m0_DAT_O, 32'hDEAD_BEEF);
        check_eq("wd_s_stb", s_STB, 0);
        step();
        m0_STB = 0;
        settle();
        check_eq("wd_idle", gnt, 2'b00);
        check_eq("wd_ack_single", m0_ACK, 0);
        check_eq("wd_flag", timeout_flag, 1);
        repeat (5) step();
        check_eq("wd_flag_sticky", timeout_flag, 1);
`else
        // ---------------- no watchdog: waits indefinitely ----------------
        begin
            int ack_seen;
            ack_seen = 0;
            m0_STB = 1;
            step();
            for (int k = 0; k < 1000; k++) begin
                if (m0_ACK) ack_seen++;
                step();
            end
            check_eq("nwd_no_ack", ack_seen, 0);
            check_eq("nwd_still_owned", gnt, 2'b01);
            check_eq("nwd_flag", timeout_flag, 0);
            m0_STB = 0;
            step();
            check_eq("nwd_abandon", gnt, 2'b00);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Two-master Wishbone arbiter placed between the bus masters and `WB_intercon`. It lets the CPU (master 0) and a second master share the single slave bus, for example a DMA/blitter writing the VGA frame buffer or a debug port. Arbitration is round-robin with one owner per transaction, and the grant is held until the slave acknowledges. An optional watchdog terminates transactions that a slave never acknowledges.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `TIMEOUT`, 255, cycles without `s_ACK` before the watchdog fires. Legal range 1..65535. Used only with `WB_ARB_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock, same domain as the CPU bus (`sclk` at top level).
- `reset` in 1: synchronous, active-high.
- `m0_STB`, `m0_WE` in 1: master 0 (CPU) strobe and write enable.
- `m0_ADDR` in `ADDR_W`: master 0 address.
- `m0_DAT_I` in `DATA_W`: master 0 write data.
- `m0_DAT_O` out `DATA_W`: master 0 read data.
- `m0_ACK` out 1: master 0 acknowledge.
- `m1_*`: same set as `m0_*`, for master 1.
- `s_STB`, `s_WE` out 1: to `WB_intercon` `master_STB` / `master_WE`.
- `s_ADDR` out `ADDR_W`: to `WB_intercon`.
- `s_DAT_O` out `DATA_W`: write data to `WB_intercon`.
- `s_DAT_I` in `DATA_W`: read data from `WB_intercon`.
- `s_ACK` in 1: acknowledge from `WB_intercon`.
- `gnt` out 2: one-hot current owner (`01` = m0, `10` = m1, `00` = none).
- `timeout_flag` out 1: sticky watchdog indicator.

## Operation
State machine with three states: IDLE, OWN0, OWN1. A `last` register holds the most recently served master; its reset value is 1, so m0 wins the first tie.

- **IDLE**
  - Only one `mX_STB` high: go to OWNX.
  - Both high: go to the master that is not `last`.
  - Neither high: stay in IDLE.
- **OWNX**
  - Drive `s_STB`/`s_WE`/`s_ADDR`/`s_DAT_O` combinationally from master X.
  - Route `s_ACK` to `mX_ACK` and `s_DAT_I` to `mX_DAT_O` combinationally.
  - The other master sees `ACK=0` and `DAT_O=0`.
- **OWNX with `s_ACK=1`:** go to IDLE and set `last<=X`.
- **OWNX with `mX_STB=0` and no ACK (master abandons):** go to IDLE; `last` is unchanged; no ACK is delivered.
- **IDLE outputs:** all `s_*` outputs 0, `gnt=00`, both `mX_ACK=0`.
- **Muxes:** each is a 2:1 select on the registered state. No arithmetic beyond the watchdog counter.

## Timing
- **Reset values:** state IDLE, `last=1`, `gnt=00`, all `s_*`=0, `mX_ACK=0`, `mX_DAT_O=0`, `timeout_flag=0`, watchdog counter 0.
- **Arbitration latency:** 1 cycle. `mX_STB` rising in cycle n gives `s_STB` in cycle n+1.
- **Back-to-back transactions:** at least one IDLE cycle between them, so total throughput is at most one transaction every 2 cycles plus slave latency.
- **ACK pass-through:** zero added latency from `s_ACK` to `mX_ACK`.
- **Master STB:** must be held until `mX_ACK`; the arbiter does not latch request payloads.
- **Both requesting continuously:** grants alternate m0, m1, m0, ...
- **New request from the same master:** a request in the cycle of its own ACK is treated as a new request and arbitrated in IDLE against the other master.
- **Reset mid-transaction:** forces IDLE next cycle. The in-flight transaction is dropped without ACK.

## Configuration
Macro `WB_ARB_TIMEOUT_EN`.

Defined:
- A counter clears on entry to OWNX and increments each OWNX cycle without `s_ACK`.
- On reaching `TIMEOUT`, in that cycle:
  - `mX_ACK=1` for exactly one cycle;
  - `mX_DAT_O=32'hDEAD_BEEF`;
  - `s_STB=0`.
- Next state is IDLE with `last<=X`.
- `timeout_flag` sets and stays 1 until reset.
- A genuine `s_ACK` in the same cycle takes priority; the timeout does not fire.

Undefined:
- No counter.
- OWNX waits indefinitely.
- `timeout_flag` is tied to 0.

## Structure
Package `wb_pkg` contains:
- state enum (IDLE/OWN0/OWN1);
- `gnt` one-hot constants `GNT_NONE`/`GNT_M0`/`GNT_M1`;
- `WB_TIMEOUT_DATA = 32'hDEAD_BEEF`.

One sub-module `wb_arb_timeout` holds the clear/enable/expire counter. It is instantiated only under the macro.

## Test plan
- **Reset:** reset held 3 cycles, then released with no STB -> `gnt=00`, all outputs 0, `timeout_flag=0`.
- **Single master:** m0 write `ADDR=0x0000_0010`, `DAT=0x1234_5678`; slave ACKs 2 cycles after `s_STB` -> `s_STB` rises 1 cycle after `m0_STB`, `m0_ACK` coincides with `s_ACK`, then `gnt` returns to `00`.
- **Simultaneous requests:** both STB asserted from cycle 0 and held, re-asserted after each ACK -> grant order m0, m1, m0, m1, with one idle cycle between each.
- **Read routing:** m1 read while m0 idle, slave returns `0xCAFE_0001` -> `m1_DAT_O=0xCAFE_0001`; `m0_ACK=0`; `m0_DAT_O=0`.
- **Abandon:** m0 drops STB in OWN0 before ACK -> IDLE next cycle; a pending m1 request is granted next, no ACK to m0.
- **Watchdog (`WB_ARB_TIMEOUT_EN`, `TIMEOUT=8`):** slave never ACKs -> `m0_ACK` pulses after 8 cycles with `0xDEAD_BEEF`, `timeout_flag=1` and stays 1; without the macro -> no ACK after 1000 cycles.
